// File: rtl/pwm_multi_ctrl.sv
// pwm_multi_ctrl: NCH-channel PWM generator sharing one period counter.
// Two push buttons (increase_duty / decrease_duty) are synchronised, debounced
// on a divided tick and edge-detected; each press steps the duty of channel
// ch_sel by one clk cycle, saturating at 0 and PERIOD.
// Optional macro PWM_SHADOW_UPDATE_EN: duty changes are held in a shadow
// register and applied at the next period start instead of immediately.
module pwm_multi_ctrl #(
  parameter int NCH     = 4,
  parameter int PERIOD  = 10,
  parameter int DEB_DIV = 2,
  localparam int CW = $clog2(PERIOD),
  localparam int DW = $clog2(PERIOD + 1),
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          increase_duty,
  input  logic          decrease_duty,
  input  logic [SW-1:0] ch_sel,
  output logic [NCH-1:0] pwm_out,
  output logic [DW-1:0] duty_rd,
  output logic          period_start
);

  localparam int TW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [DW-1:0] DMAX  = DW'(PERIOD);
  localparam logic [DW-1:0] DHALF = DW'(PERIOD / 2);
  localparam logic [CW-1:0] CMAX  = CW'(PERIOD - 1);
  localparam logic [TW-1:0] TMAX  = TW'(DEB_DIV - 1);

  // bit 0 = increase button, bit 1 = decrease button
  logic [1:0]    btn_meta, btn_sync, s1, s2, press;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic          inc_p, dec_p, ch_ok;
  logic [CW-1:0] cnt;
  logic [DW-1:0] duty        [NCH];
  logic [DW-1:0] active_duty [NCH];

  // two-flop synchroniser for both raw buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {decrease_duty, increase_duty};
      btn_sync <= btn_meta;
    end
  end

  // debounce tick divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else if (tcnt == TMAX) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  end

  assign tick = (tcnt == TMAX);

  // debounced sample pair, advanced only on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else if (tick) begin
      s1 <= btn_sync;
      s2 <= s1;
    end
  end

  assign press = s1 & ~s2 & {2{tick}};
  // simultaneous presses cancel out
  assign inc_p = press[0] & ~press[1];
  assign dec_p = press[1] & ~press[0];
  assign ch_ok = (int'(ch_sel) < NCH);

  // programmed duty registers, stepped by debounced presses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) duty[i] <= DHALF;
    end else if (ch_ok) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ch_sel == SW'(i)) begin
          if (inc_p && duty[i] != DMAX) duty[i] <= duty[i] + 1'b1;
          else if (dec_p && duty[i] != '0) duty[i] <= duty[i] - 1'b1;
        end
      end
    end
  end

`ifdef PWM_SHADOW_UPDATE_EN
  // shadow copy loaded on the last cycle of each period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) active_duty[i] <= DHALF;
    end else if (cnt == CMAX) begin
      for (int unsigned i = 0; i < NCH; i++) active_duty[i] <= duty[i];
    end
  end
`else
  // programmed duty takes effect immediately
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) active_duty[i] = duty[i];
  end
`endif

  // shared period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (cnt == CMAX) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  // registered PWM compare per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) pwm_out[i] <= (DW'(cnt) < active_duty[i]);
    end
  end

  // readback of the selected channel's programmed duty
  always_comb begin
    duty_rd = '0;
    if (ch_ok) duty_rd = duty[ch_sel];
  end

  // cnt idles at 0 during reset, so the strobe is gated by rst_n to stay low there
  assign period_start = rst_n & (cnt == '0);

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed testbench for pwm_multi_ctrl (NCH=4, PERIOD=10, DEB_DIV=2), plus a
// second instance with NCH=5 whose ch_sel is parked on the out-of-range value 5.
module tb_pwm_multi_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       increase_duty;
  logic       decrease_duty;
  logic [1:0] ch_sel;
  logic [3:0] pwm_out;
  logic [3:0] duty_rd;
  logic       period_start;

  logic [2:0] ch_sel5;
  logic [4:0] pwm_out5;
  logic [3:0] duty_rd5;
  logic       period_start5;

  int n_assert = 0;
  int n_fail   = 0;
  int hi_cnt [4];
  int ps_cnt;

  always #5 clk = ~clk;

  pwm_multi_ctrl #(.NCH(4), .PERIOD(10), .DEB_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .increase_duty(increase_duty), .decrease_duty(decrease_duty),
    .ch_sel(ch_sel), .pwm_out(pwm_out), .duty_rd(duty_rd), .period_start(period_start)
  );

  pwm_multi_ctrl #(.NCH(5), .PERIOD(10), .DEB_DIV(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .increase_duty(increase_duty), .decrease_duty(decrease_duty),
    .ch_sel(ch_sel5), .pwm_out(pwm_out5), .duty_rd(duty_rd5), .period_start(period_start5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic do_inc, input logic do_dec, input int hold);
    increase_duty = do_inc;
    decrease_duty = do_dec;
    repeat (hold) @(negedge clk);
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // count high samples per channel and period_start pulses over one period
  task automatic measure();
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    ps_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (pwm_out[i] === 1'b1) hi_cnt[i]++;
      if (period_start === 1'b1) ps_cnt++;
    end
  endtask

  // leaves the bench at the negedge of a cycle where cnt == 0
  task automatic align();
    int found;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (period_start === 1'b1) found = 1;
    end
    chk("align_period_start", found, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    ch_sel = 2'd0;
    ch_sel5 = 3'd5;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_period_start", period_start, 0);
    for (int i = 0; i < 4; i++) begin
      ch_sel = 2'(i);
      #1;
      chk($sformatf("rst_duty_ch%0d", i), duty_rd, 5);
    end
    chk("rst_dut5_oor_duty_rd", duty_rd5, 0);
    @(negedge clk);

    // release: first cycle has cnt == 0
    rst_n = 1'b1;
    #1;
    chk("first_period_start", period_start, 1);
    repeat (3) @(negedge clk);
    measure();
    for (int i = 0; i < 4; i++) chk($sformatf("idle_hi_ch%0d", i), hi_cnt[i], 5);
    chk("idle_period_start_cnt", ps_cnt, 1);

    // held button gives exactly one increment
    ch_sel = 2'd2;
    press(1'b1, 1'b0, 40);
    chk("hold_duty_rd_ch2", duty_rd, 6);
    repeat (12) @(negedge clk);
    measure();
    chk("hold_hi_ch0", hi_cnt[0], 5);
    chk("hold_hi_ch1", hi_cnt[1], 5);
    chk("hold_hi_ch2", hi_cnt[2], 6);
    chk("hold_hi_ch3", hi_cnt[3], 5);

    // saturation at 100 % and 0 %
    ch_sel = 2'd0;
    repeat (7) press(1'b1, 1'b0, 8);
    chk("sat_hi_duty_rd", duty_rd, 10);
    repeat (12) @(negedge clk);
    measure();
    chk("sat_hi_pwm_ch0", hi_cnt[0], 10);
    chk("sat_hi_period_start_cnt", ps_cnt, 1);
    repeat (12) press(1'b0, 1'b1, 8);
    chk("sat_lo_duty_rd", duty_rd, 0);
    repeat (12) @(negedge clk);
    measure();
    chk("sat_lo_pwm_ch0", hi_cnt[0], 0);
    chk("sat_lo_hi_ch2", hi_cnt[2], 6);

    // both buttons together cancel
    ch_sel = 2'd1;
    press(1'b1, 1'b1, 8);
    chk("both_duty_rd_ch1", duty_rd, 5);
    ch_sel = 2'd2;
    #1;
    chk("both_duty_rd_ch2", duty_rd, 6);

    // press pulse lands on cnt == 3 (raise at cnt 9: 2 sync + tick alignment)
    ch_sel = 2'd3;
    align();
    repeat (9) @(negedge clk);
    increase_duty = 1'b1;
    repeat (4) @(negedge clk);
    chk("timed_duty_rd_cnt3", duty_rd, 5);
    @(negedge clk);
    chk("timed_duty_rd_cnt4", duty_rd, 6);
    repeat (2) @(negedge clk);
`ifdef PWM_SHADOW_UPDATE_EN
    chk("timed_pwm3_cnt6_same_period", pwm_out[3], 0);
`else
    chk("timed_pwm3_cnt6_same_period", pwm_out[3], 1);
`endif
    @(negedge clk);
    chk("timed_pwm3_cnt7_same_period", pwm_out[3], 0);
    repeat (9) @(negedge clk);
    chk("timed_pwm3_cnt6_next_period", pwm_out[3], 1);
    increase_duty = 1'b0;
    repeat (8) @(negedge clk);

    // out-of-range channel ignored every press so far
    for (int i = 0; i < 5; i++) begin
      ch_sel5 = 3'(i);
      #1;
      chk($sformatf("oor_dut5_duty_ch%0d", i), duty_rd5, 5);
    end
    ch_sel5 = 3'd5;
    #1;
    chk("oor_dut5_duty_rd_sel5", duty_rd5, 0);

    // asynchronous reset mid-period with duty 8
    ch_sel = 2'd1;
    repeat (3) press(1'b1, 1'b0, 8);
    chk("pre_rst_duty_rd_ch1", duty_rd, 8);
    align();
    repeat (4) @(negedge clk);
    chk("pre_rst_pwm1_cnt4", pwm_out[1], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm_out", pwm_out, 0);
    chk("async_rst_period_start", period_start, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ch_sel = 2'(i);
      #1;
      chk($sformatf("post_rst_duty_ch%0d", i), duty_rd, 5);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_first_period_start", period_start, 1);
    @(negedge clk);
    chk("post_rst_period_start_cnt1", period_start, 0);
    chk("post_rst_pwm_cnt1", pwm_out, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ctrl.md
PWM_MULTI_CTRL -- requirements
Module: pwm_multi_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of PWM channels (legal 1..16).
REQ-002 Parameter PERIOD, default 10, PWM period in clk cycles (legal >= 2).
REQ-003 Parameter DEB_DIV, default 2, debounce tick divider in clk cycles (legal >= 1).
REQ-004 Derived widths: CW = clog2(PERIOD), DW = clog2(PERIOD+1), SW = max(1, clog2(NCH)).
REQ-005 clk  input  1  single clock for all logic, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 increase_duty  input  1  raw inc push button, asynchronous to clk.
REQ-008 decrease_duty  input  1  raw dec push button, asynchronous to clk.
REQ-009 ch_sel  input  SW  channel targeted by button presses and readback.
REQ-010 pwm_out  output  NCH  registered PWM output per channel.
REQ-011 duty_rd  output  DW  programmed duty of channel ch_sel.
REQ-012 period_start  output  1  one-cycle pulse when the period counter equals 0.

Function
REQ-013 Each button SHALL pass through a 2-flop synchroniser clocked every cycle.
REQ-014 Tick counter SHALL count 0..DEB_DIV-1 and wrap; tick = 1 when count == DEB_DIV-1.
REQ-015 Per button, on tick only: s1 <= sync output, s2 <= s1; press pulse = s1 & ~s2 & tick.
REQ-016 A held button SHALL produce exactly one press pulse per low-to-high transition of s1.
REQ-017 Inc pulse SHALL set duty[ch_sel] to duty+1, saturating at PERIOD (100 %).
REQ-018 Dec pulse SHALL set duty[ch_sel] to duty-1, saturating at 0 (0 %).
REQ-019 Inc and dec pulses in the same cycle SHALL leave every duty unchanged.
REQ-020 Pulses while ch_sel >= NCH SHALL be ignored; duty_rd SHALL read 0.
REQ-021 Pulses SHALL modify only the channel addressed by ch_sel in that cycle.
REQ-022 Shared period counter SHALL count 0..PERIOD-1 and wrap to 0.
REQ-023 pwm_out[i] SHALL register (cnt < active_duty[i]), one cycle after cnt.
REQ-024 duty = 0 gives constant 0; duty = PERIOD gives constant 1 with no glitch at wrap.
REQ-025 duty_rd SHALL be combinational from the programmed (not active) duty register.
REQ-026 period_start SHALL be combinational (cnt == 0), high for 1 of every PERIOD cycles.

Reset
REQ-027 While rst_n = 0: pwm_out = 0, period_start = 0, all counters and sync/debounce flops = 0.
REQ-028 While rst_n = 0: every programmed and active duty = PERIOD/2, rounded down.
REQ-029 Reset asserted mid-period SHALL clear outputs immediately, without waiting for a clk edge.
REQ-030 First clk edge after release SHALL start counting at cnt = 0.

Configuration
REQ-031 Macro PWM_SHADOW_UPDATE_EN defined: active_duty[i] SHALL load from programmed duty only on the cycle where cnt == PERIOD-1, so changes take effect at the next period start.
REQ-032 Macro undefined: active_duty[i] SHALL equal programmed duty, so a change affects pwm_out from the next clk edge.
REQ-033 In both builds, duty_rd SHALL reflect a press on the cycle after the press pulse.

Verification (NCH=4, PERIOD=10, DEB_DIV=2)
REQ-034 Release reset, no presses -> every pwm_out high 5 of each 10 cycles; period_start every 10 cycles.
REQ-035 ch_sel=2, increase_duty held 40 cycles -> exactly one increment; duty_rd=6; ch2 high 6/10; ch0, ch1, ch3 stay 5/10.
REQ-036 ch_sel=0, 7 separate inc presses -> duty_rd=10, pwm_out[0] constant 1; then 12 dec presses -> duty_rd=0, pwm_out[0] constant 0.
REQ-037 Both buttons raised together, and ch_sel=5 with inc press -> no duty changes on any channel.
REQ-038 Inc press landing at cnt=3: with PWM_SHADOW_UPDATE_EN, waveform changes only after the next period_start; without it, the waveform changes from the next clk edge.
REQ-039 rst_n pulled low at cnt=4 with duty=8 -> pwm_out=0 asynchronously; after release all duty_rd=5 and the first period_start appears on the first cycle.
